mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch path and the load/store data path of the multi-cycle RISC-V core.
- Sits between the core datapath and the BRAM.
- Decoder control outputs MemRead/MemWrite drive the data-side request.
- Sequences each access through a small FSM and returns per-requester done pulses and stall signals.
- Data side has priority, so the in-flight instruction completes before the next fetch.

Parameters:
ADDR_W, 32, byte address width on both requester ports
DATA_W, 32, data width; byte-strobe width is DATA_W/8
MEM_LATENCY, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  ADDR_W  fetch address, stable while if_req
if_rdata  out  DATA_W  fetched instruction, valid with if_valid
if_valid  out  1  one-cycle fetch completion pulse
if_stall  out  1  if_req & ~if_valid
dmem_read  in  1  load request (MemRead), level
dmem_write  in  1  store request (MemWrite), level
dmem_addr  in  ADDR_W  data address
dmem_wdata  in  DATA_W  store data
dmem_wstrb  in  DATA_W/8  store byte enables
dmem_rdata  out  DATA_W  load data, valid with dmem_done
dmem_done  out  1  one-cycle data completion pulse, loads and stores
dmem_stall  out  1  (dmem_read|dmem_write) & ~dmem_done
mem_en  out  1  RAM enable, registered
mem_we  out  DATA_W/8  RAM byte write enables, registered
mem_addr  out  ADDR_W  RAM address, registered
mem_wdata  out  DATA_W  RAM write data, registered
mem_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset is asynchronous. All registered outputs go to 0, the FSM goes to IDLE, and the latency counter goes to 0.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE: samples requests.
  - Data request (read or write) wins over if_req.
  - If dmem_read and dmem_write are both high, the access is a write.
  - The winner's address, data and strobe are registered. The FSM moves to ISSUE and records the owner (IF or D) and the kind (RD or WR).
- ISSUE: mem_en=1 for exactly one cycle.
  - mem_we = dmem_wstrb for writes, 0 for reads.
  - Writes go to RESP. Reads go to WAIT with the counter loaded to MEM_LATENCY-1.
- WAIT: counts down. When the count reaches 0, mem_rdata is captured into the owner's rdata register and the FSM moves to RESP.
  - With MEM_LATENCY=1 the capture happens in the first WAIT cycle.
- RESP: pulses the owner's done/valid for one cycle, then returns to IDLE.
- Latency from request sampled in IDLE at cycle T:
  - read done at T+2+MEM_LATENCY
  - write done at T+2
- Requesters see done at the edge closing RESP and update their req before the next IDLE sample. Requests present during ISSUE, WAIT or RESP are not sampled.
- if_rdata and dmem_rdata hold their last value until the next capture for that owner.
- A losing requester waits. Its stall stays high across the whole winner transaction.
- Inputs are ignored outside IDLE, so a requester dropping req mid-transaction does not abort the transaction. The done pulse still fires.
- Reset mid-transaction discards the in-flight access. No done pulse follows.
- Address bits [1:0] are passed through unmodified. Alignment is the datapath's responsibility.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, three 32-bit wrapping counters are present:
  - perf_if_grants: increments on each IF grant in IDLE
  - perf_d_grants: increments on each D grant in IDLE
  - perf_conflicts: increments when both sides request in the same IDLE sample
- The counters reset to 0 on rst_n and are exposed as extra output ports with those names.
- When undefined, neither the counters nor the ports exist. Core behaviour is identical in both cases.

Decomposition:
- Shared package holds:
  - arb_state_t (IDLE, ISSUE, WAIT, RESP)
  - owner encoding (OWN_IF, OWN_D)
  - default widths ADDR_W and DATA_W
- Latency countdown logic is a natural sub-module, mem_lat_counter (load, dec, zero flag).
- FSM and muxing stay in the top module.

Test Plan:
- Fetch only, MEM_LATENCY=1, if_addr=0x100, RAM[0x100]=0x00500093 -> mem_en one cycle after request; if_valid one cycle at T+3 with if_rdata=0x00500093.
- Store 0xDEADBEEF, wstrb=4'b0011, addr 0x200 -> mem_we=4'b0011 for one cycle; dmem_done at T+2; if_valid never asserts.
- if_req and dmem_read both high in the same IDLE cycle -> data served first with dmem_done; fetch issues in the next IDLE; if_stall is high throughout the data transaction.
- MEM_LATENCY=3, load from 0x40 -> dmem_done at T+5; dmem_rdata equals RAM value present 3 cycles after mem_en.
- rst_n low during WAIT of a read -> all outputs 0 immediately; no done pulse after release; the next request completes normally.
- dmem_read and dmem_write both high -> treated as a write; mem_we=dmem_wstrb; with MEM_ARB_PERF_CNT_EN, perf_d_grants increments by 1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef enum logic {
    KIND_RD = 1'b0,
    KIND_WR = 1'b1
  } kind_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Read-latency countdown: load a start value, decrement to zero, flag zero.
module mem_lat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store; data side wins.
// Optional grant/conflict counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                dmem_read,
  input  logic                dmem_write,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_wstrb,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_done,
  output logic                dmem_stall,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_grants,
  output logic [31:0]         perf_d_grants,
  output logic [31:0]         perf_conflicts
`endif
);

  localparam int CNT_W = 2;

  arb_state_t          state_q, state_d;
  owner_t              own_q, own_d;
  kind_t               kind_q, kind_d;
  logic                mem_en_q, mem_en_d;
  logic [DATA_W/8-1:0] mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dmem_rdata_q, dmem_rdata_d;
  logic                cnt_load, cnt_dec, cnt_zero;
  logic                d_req;

  assign d_req = dmem_read | dmem_write;

  mem_lat_counter #(.CNT_W(CNT_W)) u_lat (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(MEM_LATENCY - 1)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    kind_d       = kind_q;
    mem_en_d     = 1'b0;
    mem_we_d     = '0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        // Simultaneous read+write is a write; the RAM outputs are set up here
        // so they are registered and valid throughout ISSUE.
        if (d_req) begin
          own_d       = OWN_D;
          kind_d      = dmem_write ? KIND_WR : KIND_RD;
          mem_en_d    = 1'b1;
          mem_we_d    = dmem_write ? dmem_wstrb : '0;
          mem_addr_d  = dmem_addr;
          mem_wdata_d = dmem_wdata;
          state_d     = ISSUE;
        end else if (if_req) begin
          own_d      = OWN_IF;
          kind_d     = KIND_RD;
          mem_en_d   = 1'b1;
          mem_addr_d = if_addr;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (kind_q == KIND_WR) begin
          state_d = RESP;
        end else begin
          cnt_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          if (own_q == OWN_IF) if_rdata_d   = mem_rdata;
          else                 dmem_rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      own_q        <= OWN_IF;
      kind_q       <= KIND_RD;
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dmem_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      kind_q       <= kind_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign dmem_rdata = dmem_rdata_q;
  assign if_valid   = (state_q == RESP) && (own_q == OWN_IF);
  assign dmem_done  = (state_q == RESP) && (own_q == OWN_D);
  assign if_stall   = if_req & ~if_valid;
  assign dmem_stall = d_req & ~dmem_done;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_d_q, perf_cf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q <= '0;
      perf_d_q  <= '0;
      perf_cf_q <= '0;
    end else if (state_q == IDLE) begin
      if (d_req)       perf_d_q  <= perf_d_q + 32'd1;
      else if (if_req) perf_if_q <= perf_if_q + 32'd1;
      if (d_req && if_req) perf_cf_q <= perf_cf_q + 32'd1;
    end
  end

  assign perf_if_grants = perf_if_q;
  assign perf_d_grants  = perf_d_q;
  assign perf_conflicts = perf_cf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (read latency 1 and 3) run the same directed
// sequence against a cycle-indexed expectation model and a latency-accurate RAM.
module tb_mem_port_arbiter;

  localparam int NC = 512;

  logic clk;
  int   cyc = 0;
  int   checks = 0;
  int   fails  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lat_inst=%0d cyc=%0d got=%h expected=%h", nm, g, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(int i);
    if (i == 'h40) return 32'h0050_0093;
    return 32'h1000_0000 + 32'(i) * 32'h101;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst_n, if_req, dmem_read, dmem_write;
    logic [31:0] if_addr, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] if_rdata, dmem_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, if_stall, dmem_done, dmem_stall, mem_en;
    logic [3:0]  mem_we;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_valid(if_valid), .if_stall(if_stall),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
      .dmem_done(dmem_done), .dmem_stall(dmem_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
      , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
      .perf_conflicts(perf_conflicts)
`endif
    );

    // RAM: words never written read as init_word; read data is only valid
    // exactly LAT cycles after mem_en, garbage otherwise.
    bit          wrn [256];
    logic [31:0] bram [256];
    logic [3:1]  pv;
    logic [31:0] pd [1:3];

    function automatic logic [31:0] ram_word(int i);
      return wrn[i] ? bram[i] : init_word(i);
    endfunction

    always @(posedge clk) begin
      if (mem_en && (mem_we != 4'h0)) begin
        bram[mem_addr[9:2]] <= merge(ram_word(int'(mem_addr[9:2])), mem_wdata, mem_we);
        wrn[mem_addr[9:2]]  <= 1'b1;
      end
      pv    <= {pv[2:1], mem_en && (mem_we == 4'h0)};
      pd[1] <= ram_word(int'(mem_addr[9:2]));
      pd[2] <= pd[1];
      pd[3] <= pd[2];
    end
    assign mem_rdata = pv[LAT] ? pd[LAT] : (32'hBAD0_0000 | 32'(cyc));

    // Expected outputs per cycle, filled by the transaction planner.
    logic        e_en  [NC];
    logic [3:0]  e_we  [NC];
    logic [31:0] e_addr[NC];
    logic [31:0] e_wd  [NC];
    logic        e_ifv [NC];
    logic        e_dd  [NC];
    logic [31:0] e_ifr [NC];
    logic [31:0] e_dr  [NC];
    logic [31:0] mdl   [256];
    int          n_if, n_d, n_cf;
    int          obs_ifv, obs_dd;
    logic        chk_on, fin;

    task automatic plan(int t, bit own_d, bit wr, logic [31:0] a, logic [31:0] wd,
                        logic [3:0] st, output int dn);
      e_en[t+1]   = 1'b1;
      e_we[t+1]   = wr ? st : 4'h0;
      e_addr[t+1] = a;
      e_wd[t+1]   = wd;
      if (wr) begin
        mdl[a[9:2]] = merge(mdl[a[9:2]], wd, st);
        dn = t + 2;
      end else begin
        dn = t + 2 + LAT;
        for (int k = dn; k < NC; k++)
          if (own_d) e_dr[k] = mdl[a[9:2]];
          else       e_ifr[k] = mdl[a[9:2]];
      end
      if (own_d) e_dd[dn] = 1'b1;
      else       e_ifv[dn] = 1'b1;
    endtask

    task automatic clear_from(int c);
      for (int k = c; k < NC; k++) begin
        e_en[k] = 1'b0; e_we[k] = 4'h0; e_addr[k] = '0; e_wd[k] = '0;
        e_ifv[k] = 1'b0; e_dd[k] = 1'b0; e_ifr[k] = '0; e_dr[k] = '0;
      end
    endtask

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    // Presents requests in an IDLE cycle, plans the expected service order and
    // drops each request the cycle after its completion pulse.
    task automatic run(bit iq, bit rd, bit wr, logic [31:0] ia, logic [31:0] da,
                       logic [31:0] wd, logic [3:0] st, bit hold,
                       output int t, output int dd, output int fd);
      bit dq;
      int last;
      dq = rd | wr;
      t  = cyc; dd = -1; fd = -1;
      if_req = iq; if_addr = ia;
      dmem_read = rd; dmem_write = wr; dmem_addr = da; dmem_wdata = wd; dmem_wstrb = st;
      if (dq) begin plan(t, 1'b1, wr, da, wd, st, dd); n_d++; end
      if (iq) begin plan(dq ? dd + 1 : t, 1'b0, 1'b0, ia, '0, 4'h0, fd); n_if++; end
      if (iq && dq) n_cf++;
      last = (dd > fd) ? dd : fd;
      if (!hold) begin
        tick();
        if_req = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
      end
      while (cyc <= last) begin
        tick();
        if (cyc == dd + 1) begin dmem_read = 1'b0; dmem_write = 1'b0; end
        if (cyc == fd + 1) if_req = 1'b0;
      end
    endtask

    always @(negedge clk) begin
      if (chk_on && rst_n) begin
        chk("mem_en", g, 32'(mem_en), 32'(e_en[cyc]));
        chk("mem_we", g, 32'(mem_we), 32'(e_we[cyc]));
        if (e_en[cyc]) begin
          chk("mem_addr", g, mem_addr, e_addr[cyc]);
          if (e_we[cyc] != 4'h0) chk("mem_wdata", g, mem_wdata, e_wd[cyc]);
        end
        chk("if_valid", g, 32'(if_valid), 32'(e_ifv[cyc]));
        chk("dmem_done", g, 32'(dmem_done), 32'(e_dd[cyc]));
        chk("if_rdata", g, if_rdata, e_ifr[cyc]);
        chk("dmem_rdata", g, dmem_rdata, e_dr[cyc]);
        chk("if_stall", g, 32'(if_stall), 32'(if_req & ~e_ifv[cyc]));
        chk("dmem_stall", g, 32'(dmem_stall), 32'((dmem_read | dmem_write) & ~e_dd[cyc]));
        if (if_valid)  obs_ifv <= cyc;
        if (dmem_done) obs_dd  <= cyc;
      end
    end

    initial begin
      int t, dd, fd;
      fin = 1'b0; chk_on = 1'b0;
      n_if = 0; n_d = 0; n_cf = 0;
      for (int i = 0; i < 256; i++) mdl[i] = init_word(i);
      clear_from(0);
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
      dmem_read = 1'b0; dmem_write = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_en", g, 32'(mem_en), 32'd0);
      chk("rst_mem_we", g, 32'(mem_we), 32'd0);
      chk("rst_mem_addr", g, mem_addr, 32'd0);
      chk("rst_mem_wdata", g, mem_wdata, 32'd0);
      chk("rst_if_valid", g, 32'(if_valid), 32'd0);
      chk("rst_dmem_done", g, 32'(dmem_done), 32'd0);
      chk("rst_if_rdata", g, if_rdata, 32'd0);
      chk("rst_dmem_rdata", g, dmem_rdata, 32'd0);
      rst_n = 1'b1; chk_on = 1'b1;
      tick();

      // fetch from 0x100
      run(1'b1, 1'b0, 1'b0, 32'h100, '0, '0, 4'h0, 1'b1, t, dd, fd);
      chk("fetch_lat", g, 32'(obs_ifv - t), (g == 0) ? 32'd3 : 32'd5);
      chk("fetch_data", g, if_rdata, 32'h0050_0093);

      // partial store, then read it back
      run(1'b0, 1'b0, 1'b1, '0, 32'h200, 32'hDEAD_BEEF, 4'b0011, 1'b1, t, dd, fd);
      chk("store_lat", g, 32'(obs_dd - t), 32'd2);
      run(1'b0, 1'b1, 1'b0, '0, 32'h200, '0, 4'h0, 1'b1, t, dd, fd);
      chk("load_lat", g, 32'(obs_dd - t), (g == 0) ? 32'd3 : 32'd5);
      chk("load_merge", g, dmem_rdata, 32'h1000_BEEF);

      // fetch and load in the same IDLE sample: data first
      run(1'b1, 1'b1, 1'b0, 32'h104, 32'h40, '0, 4'h0, 1'b1, t, dd, fd);
      chk("conf_d_lat", g, 32'(obs_dd - t), (g == 0) ? 32'd3 : 32'd5);
      chk("conf_if_lat", g, 32'(obs_ifv - t), (g == 0) ? 32'd7 : 32'd11);
      chk("conf_d_data", g, dmem_rdata, 32'h1000_1010);
      chk("conf_if_data", g, if_rdata, 32'h1000_4141);

      // read and write together is a write
      run(1'b0, 1'b1, 1'b1, '0, 32'h44, 32'h1234_5678, 4'hF, 1'b1, t, dd, fd);
      chk("rdwr_lat", g, 32'(obs_dd - t), 32'd2);
`ifdef MEM_ARB_PERF_CNT_EN
      chk("perf_if", g, perf_if_grants, 32'd2);
      chk("perf_d", g, perf_d_grants, 32'd4);
      chk("perf_cf", g, perf_conflicts, 32'd1);
      chk("perf_d_mdl", g, perf_d_grants, 32'(n_d));
`endif
      run(1'b0, 1'b1, 1'b0, '0, 32'h44, '0, 4'h0, 1'b1, t, dd, fd);
      chk("rdwr_readback", g, dmem_rdata, 32'h1234_5678);

      // fetch whose request drops after one cycle still completes
      run(1'b1, 1'b0, 1'b0, 32'h100, '0, '0, 4'h0, 1'b0, t, dd, fd);
      chk("drop_lat", g, 32'(obs_ifv - t), (g == 0) ? 32'd3 : 32'd5);

      // reset during WAIT of a load
      t = cyc;
      dmem_read = 1'b1; dmem_addr = 32'h44;
      plan(t, 1'b1, 1'b0, 32'h44, '0, 4'h0, dd);
      tick();
      tick();
      rst_n = 1'b0; dmem_read = 1'b0;
      #1;
      chk("mid_rst_mem_en", g, 32'(mem_en), 32'd0);
      chk("mid_rst_mem_we", g, 32'(mem_we), 32'd0);
      chk("mid_rst_mem_addr", g, mem_addr, 32'd0);
      chk("mid_rst_mem_wdata", g, mem_wdata, 32'd0);
      chk("mid_rst_done", g, 32'(dmem_done), 32'd0);
      chk("mid_rst_if_rdata", g, if_rdata, 32'd0);
      chk("mid_rst_dmem_rdata", g, dmem_rdata, 32'd0);
      chk("mid_rst_dmem_stall", g, 32'(dmem_stall), 32'd0);
      clear_from(cyc);
      n_if = 0; n_d = 0; n_cf = 0;
      tick();
      rst_n = 1'b1;
      repeat (LAT + 3) tick();
      run(1'b1, 1'b0, 1'b0, 32'h100, '0, '0, 4'h0, 1'b1, t, dd, fd);
      chk("post_rst_lat", g, 32'(obs_ifv - t), (g == 0) ? 32'd3 : 32'd5);
      chk("post_rst_data", g, if_rdata, 32'h0050_0093);
`ifdef MEM_ARB_PERF_CNT_EN
      chk("post_rst_perf_if", g, perf_if_grants, 32'd1);
      chk("post_rst_perf_d", g, perf_d_grants, 32'd0);
      chk("post_rst_perf_if_mdl", g, perf_if_grants, 32'(n_if));
`endif
      tick();
      fin = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    wait (g_inst[0].fin && g_inst[1].fin);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
